// File: rtl/rgb_pkg.sv
// Shared types and colour table for the RGB pushbutton stepper.
// Holds colour index/RGB types, the six-colour table, FSM states, step helpers.
package rgb_pkg;

    localparam int NUM_COLOURS = 6;

    typedef logic [2:0] colour_idx_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t COLOUR_TABLE [NUM_COLOURS] = '{
        '{1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b0, 1'b1},
        '{1'b1, 1'b0, 1'b1}
    };

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    localparam colour_idx_t IDX_LAST = colour_idx_t'(NUM_COLOURS - 1);

    // 5 wraps to 0; the unreachable 6/7 also recover to 0.
    function automatic colour_idx_t idx_next(colour_idx_t i);
        return (i >= IDX_LAST) ? '0 : i + colour_idx_t'(1);
    endfunction

    function automatic colour_idx_t idx_prev(colour_idx_t i);
        if (i == '0)
            return IDX_LAST;
        else if (i > IDX_LAST)
            return '0;
        else
            return i - colour_idx_t'(1);
    endfunction

    function automatic rgb_t colour_of(colour_idx_t i);
        if (i <= IDX_LAST)
            return COLOUR_TABLE[i];
        else
            return '0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a raw button.
// Ports: clk, rst_n, raw (async in), level (debounced), rise/fall (accept strobes).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // rise/fall fire on the same edge that level flips, so the
    // consumer can act in step with the debounced level change.
    assign accept = (sync2 != level) && (cnt == CNT_MAX);
    assign rise   = accept && sync2;
    assign fall   = accept && !sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level || accept)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (accept)
                level <= sync2;
        end
    end

endmodule

// File: rtl/rgb_button_stepper.sv
// Steps an RGB LED through six colours, one per debounced button press.
// Ports: clk, rst_n, btn (raw), press_pulse, colour_idx[2:0], RGB_R/G/B.
// Build option RGB_BTN_REVERSE_EN: short press steps forward on release,
// long press (HOLD_CYCLES) steps backward once.
import rgb_pkg::*;

module rgb_button_stepper #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int HOLD_CYCLES     = 6000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    output logic        press_pulse,
    output logic [2:0]  colour_idx,
    output logic        RGB_R,
    output logic        RGB_G,
    output logic        RGB_B
);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_cfg
    end

    logic   lvl;
    logic   rise;
    logic   fall;
    logic   unused_level;
    state_t state;
    rgb_t   rgb;

    assign unused_level = lvl;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn),
        .level(lvl),
        .rise (rise),
        .fall (fall)
    );

`ifdef RGB_BTN_REVERSE_EN
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            press_pulse <= 1'b0;
            colour_idx  <= '0;
            hold_cnt    <= '0;
        end else begin
            press_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (rise)
                        state <= PRESSED;
                end
                PRESSED: begin
                    if (fall) begin
                        state       <= IDLE;
                        press_pulse <= 1'b1;
                        colour_idx  <= idx_next(colour_idx);
                    end else if (hold_cnt == HOLD_MAX) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        colour_idx  <= idx_prev(colour_idx);
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                HELD: begin
                    if (fall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            press_pulse <= 1'b0;
            colour_idx  <= '0;
        end else begin
            press_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        colour_idx  <= idx_next(colour_idx);
                    end
                end
                PRESSED: begin
                    if (fall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // LED drive is a register stage behind colour_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb <= '0;
        else
            rgb <= colour_of(colour_idx);
    end

    assign RGB_R = rgb.r;
    assign RGB_G = rgb.g;
    assign RGB_B = rgb.b;

endmodule

// File: tb/tb_rgb_button_stepper.sv
// Self-checking bench for rgb_button_stepper (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16).
// Vector table of press patterns plus a pulse scoreboard and reset corner cases.
module tb_rgb_button_stepper;

    localparam int D = 4;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       press_pulse;
    logic [2:0] colour_idx;
    logic       RGB_R, RGB_G, RGB_B;
    logic [2:0] rgb;

    assign rgb = {RGB_R, RGB_G, RGB_B};

    rgb_button_stepper #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .press_pulse(press_pulse),
        .colour_idx (colour_idx),
        .RGB_R      (RGB_R),
        .RGB_G      (RGB_G),
        .RGB_B      (RGB_B)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] idx;
        int         at;
    } exp_t;

    typedef struct {
        int         hi;
        int         lo;
        int         mode;
        logic [2:0] exp_idx;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[16];
    int         nv;
    int         nvec = 0;
    int         nerr = 0;
    logic [2:0] midx = 3'd0;
    logic       rgb_chk = 1'b0;
    logic [2:0] rgb_exp = 3'd0;

    function automatic logic [2:0] ref_rgb(logic [2:0] i);
        case (i)
            3'd0: return 3'b100;
            3'd1: return 3'b110;
            3'd2: return 3'b010;
            3'd3: return 3'b011;
            3'd4: return 3'b001;
            3'd5: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] nxt(logic [2:0] i);
        return (i == 3'd5) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [2:0] prv(logic [2:0] i);
        return (i == 3'd0) ? 3'd5 : i - 3'd1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rgb_chk) begin
            rgb_chk = 1'b0;
            check("pulse_rgb", rgb, rgb_exp);
        end
        if (rst_n && press_pulse) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_pulse: got idx %0d at cycle %0d want no pulse",
                         colour_idx, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_idx", colour_idx, e.idx);
                check("pulse_cycle", cyc, e.at);
                rgb_exp = ref_rgb(e.idx);
                rgb_chk = 1'b1;
            end
        end
    end

    // mode: 0 none, 1 step on press, 2 step on release, 3 back-step at hold
    task automatic press(int hi, int lo, int mode);
        @(posedge clk);
        #1;
        if (mode == 1) begin
            midx = nxt(midx);
            sb.push_back('{midx, cyc + 2 + D});
        end
        if (mode == 3) begin
            midx = prv(midx);
            sb.push_back('{midx, cyc + 2 + D + H});
        end
        btn = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        if (mode == 2) begin
            midx = nxt(midx);
            sb.push_back('{midx, cyc + 2 + D});
        end
        btn = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    initial begin
`ifdef RGB_BTN_REVERSE_EN
        vt[0] = '{10, 20, 2, 3'd1};
        vt[1] = '{40, 20, 3, 3'd0};
        nv = 2;
`else
        vt[0] = '{20, 20, 1, 3'd1};
        for (int i = 1; i <= 10; i++)
            vt[i] = '{3, 3, 0, 3'd1};
        vt[11] = '{20, 20, 1, 3'd2};
        vt[12] = '{20, 20, 1, 3'd3};
        vt[13] = '{20, 20, 1, 3'd4};
        vt[14] = '{20, 20, 1, 3'd5};
        vt[15] = '{20, 20, 1, 3'd0};
        nv = 16;
`endif

        rst_n = 1'b0;
        btn   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_idx", colour_idx, 3'd0);
        check("rst_rgb", rgb, 3'b000);
        check("rst_pulse", press_pulse, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_rgb", rgb, 3'b100);
        check("first_idx", colour_idx, 3'd0);
        repeat (5) @(negedge clk);
        check("idle_pulse", press_pulse, 1'b0);

        for (int i = 0; i < nv; i++) begin
            press(vt[i].hi, vt[i].lo, vt[i].mode);
            @(negedge clk);
            check($sformatf("vec%0d_idx", i), colour_idx, vt[i].exp_idx);
            check($sformatf("vec%0d_rgb", i), rgb, ref_rgb(vt[i].exp_idx));
        end

`ifndef RGB_BTN_REVERSE_EN
        press(20, 20, 1);
        press(20, 20, 1);
        @(posedge clk);
        #1;
        midx = 3'd3;
        sb.push_back('{3'd3, cyc + 2 + D});
        btn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("held_idx", colour_idx, 3'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_idx", colour_idx, 3'd0);
        check("midrst_rgb", rgb, 3'b000);
        check("midrst_pulse", press_pulse, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        midx = 3'd1;
        sb.push_back('{3'd1, cyc + 2 + D});
        repeat (15) @(negedge clk);
        check("post_rst_idx", colour_idx, 3'd1);
        check("post_rst_rgb", rgb, 3'b110);
        @(posedge clk);
        #1;
        btn = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("final_idx", colour_idx, midx);
`endif

        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
